// File: rtl/alu_logic_pkg.sv
// Shared types for the iterative bitwise logic unit: op encodings and FSM states.
package alu_logic_pkg;

   typedef enum logic [2:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_XOR  = 3'b010,
      OP_XNOR = 3'b011,
      OP_NAND = 3'b100,
      OP_NOR  = 3'b101,
      OP_NOTA = 3'b110,
      OP_PASS = 3'b111
   } logic_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } liu_state_e;

endpackage

// File: rtl/logic_slice.sv
// Combinational CHUNK-bit slice: applies one bitwise op and counts the ones it produced.
module logic_slice
   import alu_logic_pkg::*;
#(
   parameter int unsigned CHUNK  = 4,
   parameter int unsigned ONES_W = $clog2(CHUNK + 1)
) (
   input  logic_op_e         op,
   input  logic [CHUNK-1:0]  a_chunk,
   input  logic [CHUNK-1:0]  b_chunk,
   output logic [CHUNK-1:0]  res_chunk,
   output logic [ONES_W-1:0] chunk_ones
);

   always_comb begin
      res_chunk = '0;
      unique case (op)
         OP_AND:  res_chunk = a_chunk & b_chunk;
         OP_OR:   res_chunk = a_chunk | b_chunk;
         OP_XOR:  res_chunk = a_chunk ^ b_chunk;
         OP_XNOR: res_chunk = ~(a_chunk ^ b_chunk);
         OP_NAND: res_chunk = ~(a_chunk & b_chunk);
         OP_NOR:  res_chunk = ~(a_chunk | b_chunk);
         OP_NOTA: res_chunk = ~a_chunk;
         OP_PASS: res_chunk = a_chunk;
         default: res_chunk = '0;
      endcase
   end

   always_comb begin
      chunk_ones = '0;
      for (int i = 0; i < int'(CHUNK); i++) begin
         chunk_ones = chunk_ones + ONES_W'(res_chunk[i]);
      end
   end

endmodule

// File: rtl/logic_unit_iter.sv
// Iterative bitwise logic unit: evaluates one op CHUNK bits per cycle, LSB chunk first,
// accumulating zero/parity/popcount flags, with valid/ready on both sides.
module logic_unit_iter
   import alu_logic_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CHUNK = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [2:0]                     op,
   input  logic [WIDTH-1:0]               a,
   input  logic [WIDTH-1:0]               b,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [WIDTH-1:0]               result,
   output logic                           zero,
   output logic                           parity,
   output logic [$clog2(WIDTH+1)-1:0]     popcnt
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
   localparam int unsigned ONES_W = $clog2(CHUNK + 1);
   localparam int unsigned K_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   if (CHUNK < 1) begin : g_bad_chunk
      $error("logic_unit_iter: CHUNK must be at least 1");
   end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
      $error("logic_unit_iter: WIDTH must be a multiple of CHUNK");
   end

   liu_state_e        state_q, state_d;
   logic_op_e         op_q;
   logic [WIDTH-1:0]  a_q, b_q;
   logic [K_W-1:0]    k_q;
   logic              accept_c, step_c, last_c, release_c;
   logic [CHUNK-1:0]  res_chunk;
   logic [ONES_W-1:0] chunk_ones;
   logic [CNT_W-1:0]  pop_nxt;

   assign in_ready = (state_q == IDLE);
   assign last_c   = (k_q == K_W'(NCHUNK - 1));
   assign pop_nxt  = popcnt + CNT_W'(chunk_ones);

   logic_slice #(.CHUNK(CHUNK), .ONES_W(ONES_W)) u_slice (
      .op         (op_q),
      .a_chunk    (a_q[k_q*CHUNK +: CHUNK]),
      .b_chunk    (b_q[k_q*CHUNK +: CHUNK]),
      .res_chunk  (res_chunk),
      .chunk_ones (chunk_ones)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state plus the per-cycle datapath enables.
   always_comb begin
      state_d   = state_q;
      accept_c  = 1'b0;
      step_c    = 1'b0;
      release_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               accept_c = 1'b1;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            step_c = 1'b1;
            if (last_c) state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               release_c = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q      <= OP_AND;
         a_q       <= '0;
         b_q       <= '0;
         k_q       <= '0;
         result    <= '0;
         popcnt    <= '0;
         parity    <= 1'b0;
         zero      <= 1'b0;
         out_valid <= 1'b0;
      end else if (accept_c) begin
         op_q   <= logic_op_e'(op);
         a_q    <= a;
         b_q    <= b;
         k_q    <= '0;
         result <= '0;
         popcnt <= '0;
         parity <= 1'b0;
         zero   <= 1'b0;
      end else if (step_c) begin
         result[k_q*CHUNK +: CHUNK] <= res_chunk;
         popcnt <= pop_nxt;
         parity <= parity ^ (^res_chunk);
         k_q    <= K_W'(k_q + 1'b1);
         if (last_c) begin
            out_valid <= 1'b1;
            zero      <= (pop_nxt == '0);
         end
      end else if (release_c) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_logic_unit_iter.sv
// Randomized and directed bench for logic_unit_iter (8/4 and 32/8 instances) against a behavioural model.
module tb_logic_unit_iter;

   logic       clk = 1'b0;
   logic       rst_n;
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;

   logic       in_valid, in_ready, out_valid, out_ready, zero, parity;
   logic [2:0] op;
   logic [7:0] a, b, result;
   logic [3:0] popcnt;

   logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w, zero_w, parity_w;
   logic [2:0]  op_w;
   logic [31:0] a_w, b_w, result_w;
   logic [5:0]  popcnt_w;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   logic_unit_iter #(.WIDTH(8), .CHUNK(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .zero(zero), .parity(parity), .popcnt(popcnt)
   );

   logic_unit_iter #(.WIDTH(32), .CHUNK(8)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w), .op(op_w),
      .a(a_w), .b(b_w), .out_valid(out_valid_w), .out_ready(out_ready_w), .result(result_w),
      .zero(zero_w), .parity(parity_w), .popcnt(popcnt_w)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference semantics of the eight op codes on full-width words.
   function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      case (o)
         3'd0:    return x & y;
         3'd1:    return x | y;
         3'd2:    return x ^ y;
         3'd3:    return ~(x ^ y);
         3'd4:    return ~(x & y);
         3'd5:    return ~(x | y);
         3'd6:    return ~x;
         default: return x;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                       input int stall, input bit poke, input string tag);
      logic [7:0] e;
      int lat;
      e = 8'(ref_op(o, {24'h0, x}, {24'h0, y}));
      lat = 0;
      while (!in_ready && lat < 20) begin step(); lat++; end
      check({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
      op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin step(); lat++; end
      check({tag, " latency"}, 64'(lat), 64'd2);
      check({tag, " result"}, 64'(result), 64'(e));
      check({tag, " popcnt"}, 64'(popcnt), 64'($countones(e)));
      check({tag, " parity"}, 64'(parity), 64'(^e));
      check({tag, " zero"}, 64'(zero), 64'(e == 8'h00));
      check({tag, " in_ready busy"}, 64'(in_ready), 64'd0);
      for (int s = 0; s < stall; s++) begin
         if (poke && s == 1) begin
            in_valid = 1'b1; op = ~o; a = ~x; b = ~y;
         end
         step();
         in_valid = 1'b0;
         check({tag, " stall valid"}, 64'(out_valid), 64'd1);
         check({tag, " stall result"}, 64'(result), 64'(e));
         check({tag, " stall popcnt"}, 64'(popcnt), 64'($countones(e)));
         check({tag, " stall in_ready"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, " released"}, 64'(out_valid), 64'd0);
      check({tag, " ready again"}, 64'(in_ready), 64'd1);
      check({tag, " held result"}, 64'(result), 64'(e));
   endtask

   task automatic run32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
      logic [31:0] e;
      int lat;
      e = ref_op(o, x, y);
      op_w = o; a_w = x; b_w = y; in_valid_w = 1'b1; out_ready_w = 1'b0;
      step();
      in_valid_w = 1'b0;
      lat = 0;
      while (!out_valid_w && lat < 20) begin step(); lat++; end
      check({tag, " latency"}, 64'(lat), 64'd4);
      check({tag, " result"}, 64'(result_w), 64'(e));
      check({tag, " popcnt"}, 64'(popcnt_w), 64'($countones(e)));
      check({tag, " parity"}, 64'(parity_w), 64'(^e));
      check({tag, " zero"}, 64'(zero_w), 64'(e == 32'h0));
      out_ready_w = 1'b1;
      step();
      out_ready_w = 1'b0;
      check({tag, " released"}, 64'(out_valid_w), 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [2:0] ops [3];
      logic [7:0] exps [3];
      int acc [3];
      int lat;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
      in_valid_w = 1'b0; out_ready_w = 1'b0; op_w = '0; a_w = '0; b_w = '0;
      #2;
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset result", 64'(result), 64'd0);
      check("reset popcnt", 64'(popcnt), 64'd0);
      check("reset zero", 64'(zero), 64'd0);
      check("reset parity", 64'(parity), 64'd0);
      check("reset in_ready", 64'(in_ready), 64'd1);
      step(); step();
      rst_n = 1'b1;
      step();

      run8(3'b011, 8'hA5, 8'h0F, 0, 1'b0, "xnor");
      run8(3'b010, 8'h3C, 8'h3C, 0, 1'b0, "xor_zero");
      run8(3'b000, 8'hF0, 8'h3C, 5, 1'b1, "backpressure");

      // Reset after the first chunk has been written.
      op = 3'b010; a = 8'hA5; b = 8'h0F; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      check("midop partial", 64'(result), 64'h0A);
      rst_n = 1'b0;
      #1;
      check("midop out_valid", 64'(out_valid), 64'd0);
      check("midop result", 64'(result), 64'd0);
      check("midop popcnt", 64'(popcnt), 64'd0);
      check("midop in_ready", 64'(in_ready), 64'd1);
      step();
      rst_n = 1'b1;
      step();
      check("post reset in_ready", 64'(in_ready), 64'd1);
      check("post reset out_valid", 64'(out_valid), 64'd0);
      run8(3'b101, 8'h00, 8'h01, 0, 1'b0, "nor");

      run32(3'b100, 32'hFFFF0000, 32'hFFFFFFFF, "w32 nand");
      run32(3'b110, 32'h00000000, 32'h12345678, "w32 nota");
      run32(3'b010, 32'hDEADBEEF, 32'hDEADBEEF, "w32 xor zero");

      // Back-to-back with in_valid and out_ready held high.
      ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b111;
      exps[0] = 8'h30; exps[1] = 8'hFC; exps[2] = 8'hF0;
      a = 8'hF0; b = 8'h3C; out_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         op = ops[i];
         lat = 0;
         while (!in_ready && lat < 20) begin step(); lat++; end
         acc[i] = cyc;
         step();
         lat = 0;
         while (!out_valid && lat < 20) begin step(); lat++; end
         check("b2b latency", 64'(lat), 64'd2);
         check("b2b result", 64'(result), 64'(exps[i]));
      end
      in_valid = 1'b0;
      step();
      out_ready = 1'b0;
      check("b2b period 0-1", 64'(acc[1] - acc[0]), 64'd4);
      check("b2b period 1-2", 64'(acc[2] - acc[1]), 64'd4);

      for (int n = 0; n < 40; n++) begin
         run8(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
